pes_pwm: RTL and testbench



---
 rtl/pes_pwm.sv | 112 +++++++++++
 tb/tb_pes_pwm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pes_pwm.sv
// Button-stepped PWM generator: synchronised, debounced inc/dec presses step a saturating duty.
// Optional duty status outputs are enabled by defining PES_PWM_DUTY_STATUS_EN.
module pes_pwm #(
  parameter int unsigned PERIOD       = 10,
  parameter int unsigned DUTY_RESET   = 5,
  parameter int unsigned DEBOUNCE_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic increase_duty,
  input  logic decrease_duty,
  output logic PWM_OUT
`ifdef PES_PWM_DUTY_STATUS_EN
  ,
  output logic [$clog2(PERIOD+1)-1:0] duty_level,
  output logic                        duty_limit
`endif
);

  localparam int unsigned W  = $clog2(PERIOD + 1);
  localparam int unsigned PW = $clog2(DEBOUNCE_DIV);

  localparam logic [W-1:0]  DUTY_MAX  = W'(PERIOD);
  localparam logic [W-1:0]  CNT_LAST  = W'(PERIOD - 1);
  localparam logic [W-1:0]  DUTY_INIT = W'(DUTY_RESET);
  localparam logic [PW-1:0] PRE_LAST  = PW'(DEBOUNCE_DIV - 1);

  // Bit 0 = increase, bit 1 = decrease throughout.
  logic [1:0]    btn;
  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [1:0]    smp [2];
  logic [1:0]    acc;
  logic [1:0]    acc_q;
  logic [1:0]    armed;
  logic [1:0]    press;
  logic [1:0]    fill;
  logic [PW-1:0] pre;
  logic          tick;
  logic [W-1:0]  cnt;
  logic [W-1:0]  duty_next;
  logic [W-1:0]  duty_active;
  logic [W-1:0]  duty_nx;

  assign btn  = {decrease_duty, increase_duty};
  assign tick = (pre == PRE_LAST);

  // A button only arms once two genuine low samples have been taken after reset,
  // so a button held through reset release is not mistaken for a new press.
  assign press = acc & ~acc_q & armed;

  always_comb begin
    duty_nx = duty_next;
    case (press)
      2'b01:   if (duty_next < DUTY_MAX) duty_nx = duty_next + W'(1);
      2'b10:   if (duty_next != '0)      duty_nx = duty_next - W'(1);
      default: duty_nx = duty_next;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta        <= '0;
      sync        <= '0;
      for (int unsigned i = 0; i < 2; i++) smp[i] <= '0;
      acc         <= '0;
      acc_q       <= '0;
      armed       <= '0;
      fill        <= '0;
      pre         <= '0;
      cnt         <= '0;
      duty_next   <= DUTY_INIT;
      duty_active <= DUTY_INIT;
      PWM_OUT     <= 1'b0;
`ifdef PES_PWM_DUTY_STATUS_EN
      duty_level  <= DUTY_INIT;
      duty_limit  <= 1'b0;
`endif
    end else begin
      meta <= btn;
      sync <= meta;

      pre <= tick ? '0 : pre + PW'(1);
      if (tick && fill != 2'd2) fill <= fill + 2'd1;

      for (int unsigned i = 0; i < 2; i++) begin
        if (tick)                  smp[i]   <= {smp[i][0], sync[i]};
        if (smp[i][1] == smp[i][0]) acc[i]  <= smp[i][0];
        if (fill == 2'd2 && smp[i] == 2'b00) armed[i] <= 1'b1;
      end
      acc_q <= acc;

      duty_next <= duty_nx;

      if (cnt == CNT_LAST) begin
        cnt         <= '0;
        duty_active <= duty_next;
`ifdef PES_PWM_DUTY_STATUS_EN
        duty_level  <= duty_next;
`endif
      end else begin
        cnt <= cnt + W'(1);
      end

      PWM_OUT <= (cnt < duty_active);
`ifdef PES_PWM_DUTY_STATUS_EN
      duty_limit <= (duty_nx == '0) || (duty_nx == DUTY_MAX);
`endif
    end
  end

endmodule

// File: tb/tb_pes_pwm.sv
// Directed bench for pes_pwm: table of button presses with expected high cycles per period,
// plus sequences for mid-period change, asynchronous reset and button held through reset.
module tb_pes_pwm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic increase_duty = 1'b0;
  logic decrease_duty = 1'b0;
  logic PWM_OUT;
`ifdef PES_PWM_DUTY_STATUS_EN
  logic [3:0] duty_level;
  logic       duty_limit;
`endif

  always #5 clk = ~clk;

  pes_pwm #(
    .PERIOD(10),
    .DUTY_RESET(5),
    .DEBOUNCE_DIV(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .increase_duty(increase_duty),
    .decrease_duty(decrease_duty),
    .PWM_OUT(PWM_OUT)
`ifdef PES_PWM_DUTY_STATUS_EN
    ,
    .duty_level(duty_level),
    .duty_limit(duty_limit)
`endif
  );

  typedef struct {
    logic        inc;
    logic        dec;
    int unsigned len;
    int unsigned exp_high;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic inc, input logic dec, input int unsigned len,
                     input int unsigned exp_high);
    vec_t v;
    v.inc = inc; v.dec = dec; v.len = len; v.exp_high = exp_high;
    vecs.push_back(v);
  endtask

  task automatic count_high(input int unsigned n, output int unsigned h);
    h = 0;
    repeat (n) begin
      @(negedge clk);
      if (PWM_OUT) h++;
    end
  endtask

  task automatic press(input logic inc, input logic dec, input int unsigned len);
    increase_duty = inc;
    decrease_duty = dec;
    repeat (len) @(negedge clk);
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Stops on the negedge where PWM_OUT first reads high in a period.
  task automatic align(output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = PWM_OUT;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!prev && PWM_OUT) ok = 1'b1;
      prev = PWM_OUT;
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned h;
    int unsigned edges;
    logic        prev;
    bit          ok;
    logic [59:0] bits;
    int unsigned hp [6];
    bit          contig;

    // From reset duty 5: five incs to 10, saturate, nine decs to 1, floor at 0,
    // then simultaneous, long-hold and glitch cases.
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 10, 6 + i);
    add(1'b1, 1'b0, 10, 10);
    for (int i = 0; i < 9; i++) add(1'b0, 1'b1, 10, 9 - i);
    add(1'b0, 1'b1, 10, 0);
    add(1'b0, 1'b1, 10, 0);
    add(1'b1, 1'b0, 10, 1);
    add(1'b1, 1'b1, 10, 1);
    add(1'b1, 1'b0, 200, 2);
    add(1'b1, 1'b0, 2, 2);
    add(1'b0, 1'b1, 2, 2);
    add(1'b1, 1'b1, 200, 2);

    #1;
    check("reset_pwm_low", PWM_OUT, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    h = 0; edges = 0; prev = PWM_OUT;
    repeat (50) begin
      @(negedge clk);
      if (PWM_OUT) h++;
      if (PWM_OUT && !prev) edges++;
      prev = PWM_OUT;
    end
    check("reset_high_in_50", h, 25);
    check("reset_periods_in_50", edges, 5);

    foreach (vecs[i]) begin
      press(vecs[i].inc, vecs[i].dec, vecs[i].len);
      repeat (20) @(negedge clk);
      count_high(10, h);
      check($sformatf("vec%0d_high", i), h, vecs[i].exp_high);
`ifdef PES_PWM_DUTY_STATUS_EN
      check($sformatf("vec%0d_level", i), duty_level, vecs[i].exp_high);
      check($sformatf("vec%0d_limit", i), duty_limit,
            (vecs[i].exp_high == 0 || vecs[i].exp_high == 10) ? 1 : 0);
`endif
    end

    // Press accepted mid-period: periods must stay whole, switching 5 -> 6 at a wrap.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    align(ok);
    check("mid_align", ok, 1);
    bits[0] = PWM_OUT;
    for (int i = 1; i < 60; i++) begin
      if (i == 3)  increase_duty = 1'b1;
      if (i == 13) increase_duty = 1'b0;
      @(negedge clk);
      bits[i] = PWM_OUT;
    end
    for (int k = 0; k < 6; k++) begin
      hp[k] = 0;
      for (int j = 0; j < 10; j++) if (bits[10*k + j]) hp[k]++;
      contig = 1'b1;
      for (int j = 0; j < 10; j++)
        if (bits[10*k + j] != (j < int'(hp[k]))) contig = 1'b0;
      check($sformatf("mid_p%0d_contiguous", k), contig, 1);
      check($sformatf("mid_p%0d_in_range", k), (hp[k] == 5 || hp[k] == 6) ? 1 : 0, 1);
      if (k > 0) check($sformatf("mid_p%0d_monotonic", k), (hp[k] >= hp[k-1]) ? 1 : 0, 1);
    end
    check("mid_first_period", hp[0], 5);
    check("mid_last_period", hp[5], 6);
    repeat (20) @(negedge clk);

    // Asynchronous reset during the high phase.
    align(ok);
    check("arst_align", ok, 1);
    check("arst_pre_high", PWM_OUT, 1);
    #2 rst_n = 1'b0;
    #1 check("arst_async_low", PWM_OUT, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    count_high(10, h);
    check("arst_duty_back_50", h, 5);

    // Button held through reset release must not count until released and pressed again.
    rst_n = 1'b0;
    increase_duty = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    count_high(10, h);
    check("held_no_press", h, 5);
    increase_duty = 1'b0;
    repeat (30) @(negedge clk);
    count_high(10, h);
    check("held_release", h, 5);
    press(1'b1, 1'b0, 10);
    repeat (20) @(negedge clk);
    count_high(10, h);
    check("held_repress", h, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
